// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline hazard FSM: load-use stall, memory-wait freeze, branch flush
// Priority is dmem_busy > branch taken > load-use; outputs are combinational from state and inputs.
module hazard_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IF_ID_rn,
  input  logic [4:0]  IF_ID_rm,
  input  logic        IF_ID_useRm,
  input  logic [4:0]  ID_EX_rd,
  input  logic        ID_EX_memRead,
  input  logic        EX_MEM_branchTaken,
  input  logic        dmem_busy,
  output logic        pc_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic [1:0]  hz_state,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10,
    FLUSH      = 2'b11
  } state_t;

  state_t state;
  state_t next_state;
  logic   load_use;

  // X31 reads as zero, so a load targeting it can never feed a consumer
  assign load_use = ID_EX_memRead && (ID_EX_rd != 5'd31) &&
                    ((ID_EX_rd == IF_ID_rn) ||
                     (IF_ID_useRm && (ID_EX_rd == IF_ID_rm)));

  always_comb begin
    pc_write    = 1'b1;
    IF_ID_write = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    next_state  = RUN;
    if (!reset) begin
      if (dmem_busy) begin
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        next_state  = MEM_WAIT;
      end else if (EX_MEM_branchTaken) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
        next_state  = FLUSH;
      end else if (load_use && (state != FLUSH)) begin
        // IF/ID holds a flushed bubble in FLUSH, so any match there is stale
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        ID_EX_flush = 1'b1;
        next_state  = LOAD_STALL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      stall_count <= 16'd0;
    end else begin
      state <= next_state;
      if (!pc_write && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

  assign hz_state = state;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - table-driven and sequence checks for hazard_control_unit
module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  IF_ID_rn, IF_ID_rm, ID_EX_rd;
  logic        IF_ID_useRm, ID_EX_memRead, EX_MEM_branchTaken, dmem_busy;
  logic        pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush;
  logic [1:0]  hz_state;
  logic [15:0] stall_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  hazard_control_unit dut (
    .clk(clk), .reset(reset),
    .IF_ID_rn(IF_ID_rn), .IF_ID_rm(IF_ID_rm), .IF_ID_useRm(IF_ID_useRm),
    .ID_EX_rd(ID_EX_rd), .ID_EX_memRead(ID_EX_memRead),
    .EX_MEM_branchTaken(EX_MEM_branchTaken), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_flush(ID_EX_flush), .hz_state(hz_state), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rn, rm, rd;
    logic       use_rm, mem_read, br, busy;
    logic [3:0] exp_ctl;   // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush}
    logic [1:0] exp_next;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] rn, input logic [4:0] rm, input logic use_rm,
                        input logic [4:0] rd, input logic mem_read, input logic br,
                        input logic busy);
    IF_ID_rn = rn; IF_ID_rm = rm; IF_ID_useRm = use_rm; ID_EX_rd = rd;
    ID_EX_memRead = mem_read; EX_MEM_branchTaken = br; dmem_busy = busy;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [3:0] ctl();
    return {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush};
  endfunction

  initial begin
    vecs[0]  = '{"idle",        5'd1, 5'd2, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, 2'b00};
    vecs[1]  = '{"lu_rn",       5'd5, 5'd2, 5'd5,  1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 2'b01};
    vecs[2]  = '{"xzr_rn",      5'd31,5'd2, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1100, 2'b00};
    vecs[3]  = '{"rm_unused",   5'd1, 5'd7, 5'd7,  1'b0, 1'b1, 1'b0, 1'b0, 4'b1100, 2'b00};
    vecs[4]  = '{"rm_used",     5'd1, 5'd7, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 2'b01};
    vecs[5]  = '{"no_load",     5'd5, 5'd2, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 2'b00};
    vecs[6]  = '{"busy",        5'd1, 5'd2, 5'd3,  1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 2'b10};
    vecs[7]  = '{"branch",      5'd1, 5'd2, 5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 2'b11};
    vecs[8]  = '{"busy_br_lu",  5'd5, 5'd2, 5'd5,  1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 2'b10};
    vecs[9]  = '{"br_lu",       5'd5, 5'd2, 5'd5,  1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 2'b11};
    vecs[10] = '{"xzr_rm",      5'd1, 5'd31,5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1100, 2'b00};

    do_reset();
    check("reset_state", {14'd0, hz_state}, 16'd0);
    check("reset_count", stall_count, 16'd0);
    check("reset_ctl", {12'd0, ctl()}, 16'b1100);

    reset = 1'b1;
    set_in(5'd5, 5'd2, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
    check("reset_overrides_ctl", {12'd0, ctl()}, 16'b1100);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_reset();
      set_in(vecs[i].rn, vecs[i].rm, vecs[i].use_rm, vecs[i].rd,
             vecs[i].mem_read, vecs[i].br, vecs[i].busy);
      check({vecs[i].name, "_ctl"}, {12'd0, ctl()}, {12'd0, vecs[i].exp_ctl});
      tick();
      check({vecs[i].name, "_next"}, {14'd0, hz_state}, {14'd0, vecs[i].exp_next});
    end

    // load-use: one stall cycle, then LOAD_STALL with defaults, then RUN
    do_reset();
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    check("lu_stall_ctl", {12'd0, ctl()}, 16'b0001);
    tick();
    set_in(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lu_state", {14'd0, hz_state}, 16'd1);
    check("lu_after_ctl", {12'd0, ctl()}, 16'b1100);
    tick();
    check("lu_back_run", {14'd0, hz_state}, 16'd0);
    check("lu_count", stall_count, 16'd1);

    // memory wait for 3 cycles with LU and branch pending
    do_reset();
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      check("mw_freeze_ctl", {12'd0, ctl()}, 16'b0000);
      tick();
    end
    check("mw_state", {14'd0, hz_state}, 16'd2);
    check("mw_count", stall_count, 16'd3);
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    check("mw_then_lu_ctl", {12'd0, ctl()}, 16'b0001);
    tick();
    check("mw_then_lu_state", {14'd0, hz_state}, 16'd1);
    check("mw_then_lu_count", stall_count, 16'd4);

    // branch flush, LU ignored in FLUSH, busy still honoured there
    do_reset();
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    check("br_ctl", {12'd0, ctl()}, 16'b1111);
    tick();
    check("br_state", {14'd0, hz_state}, 16'd3);
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    check("flush_lu_ignored", {12'd0, ctl()}, 16'b1100);
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
    check("flush_busy_ctl", {12'd0, ctl()}, 16'b0000);
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    check("flush_to_run", {14'd0, hz_state}, 16'd0);
    check("flush_count", stall_count, 16'd0);

    // reset during LOAD_STALL clears everything
    do_reset();
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    check("rls_in_stall", {14'd0, hz_state}, 16'd1);
    reset = 1'b1;
    #1;
    check("rls_reset_ctl", {12'd0, ctl()}, 16'b1100);
    tick();
    reset = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("rls_state", {14'd0, hz_state}, 16'd0);
    check("rls_count", stall_count, 16'd0);
    check("rls_ctl", {12'd0, ctl()}, 16'b1100);

    // saturation then reset
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    repeat (65540) tick();
    check("sat_count", stall_count, 16'hFFFF);
    check("sat_state", {14'd0, hz_state}, 16'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("sat_reset_state", {14'd0, hz_state}, 16'd0);
    check("sat_reset_count", stall_count, 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
